slave_port: RTL and testbench

- Slave-side endpoint of the bit-serial system bus; the counterpart of the master port.
- Receives a serial header (address + burst count), then either:
  - deserialises write words into a local memory, or
  - reads words from that memory and serialises them back to the master.
- Sits between the bus interconnect (already slave-selected) and one slave's local memory.

---
 rtl/slave_port.sv | 133 +++++++++++++
 tb/tb_slave_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port.sv
// slave_port: bit-serial bus slave endpoint bridging serial header/data beats to a local word memory.
// Optional macro SLAVE_PARITY_EN appends an even-parity bit to every data word and adds parity_err.
module slave_port #(
  parameter int ADDR_LEN = 12,
  parameter int DATA_LEN = 8,
  parameter int BURST_LEN = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                selected,
  input  logic                master_valid,
  input  logic                master_ready,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_burst_number,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic                slave_valid,
  output logic                tx_data,
  output logic                rx_done,
  output logic                tx_done,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_LEN-1:0] mem_rdata
`ifdef SLAVE_PARITY_EN
  ,
  output logic                parity_err
`endif
);
  localparam int HDR_LEN = ADDR_LEN > BURST_LEN ? ADDR_LEN : BURST_LEN;
`ifdef SLAVE_PARITY_EN
  localparam int WORD_LEN = DATA_LEN + 1;
`else
  localparam int WORD_LEN = DATA_LEN;
`endif
  localparam int CW = $clog2((HDR_LEN > WORD_LEN ? HDR_LEN : WORD_LEN) + 1);
  localparam logic [CW-1:0] A_END = CW'(ADDR_LEN);
  localparam logic [CW-1:0] B_END = CW'(BURST_LEN);
  localparam logic [CW-1:0] H_LAST = CW'(HDR_LEN - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WORD_LEN - 1);
  typedef enum logic [2:0] {IDLE, HDR, WDATA, WSTORE, RFETCH, RWAIT, RSHIFT, DONE} state_t;
  state_t               state;
  logic                 is_write;
  logic [ADDR_LEN-1:0]  addr;
  logic [BURST_LEN-1:0] burst;
  logic [CW-1:0]        cnt;
  logic [WORD_LEN-1:0]  shreg;
  logic                 beat, last_word, word_ok;
  assign beat = master_valid && slave_ready;
  assign last_word = burst <= BURST_LEN'(1);
`ifdef SLAVE_PARITY_EN
  assign word_ok = ~^shreg;
`else
  assign word_ok = 1'b1;
`endif
  // IDLE follows selected; gating with reset keeps every output low while reset is held
  assign slave_ready = reset && (state == IDLE ? selected : (state == HDR || state == WDATA));
  assign slave_valid = state == RSHIFT;
  assign tx_data = slave_valid && shreg[0];
  assign rx_done = state == DONE && is_write;
  assign tx_done = state == DONE && !is_write;
  assign mem_we = state == WSTORE && word_ok;
  assign mem_re = state == RFETCH;
  assign mem_addr = (state == WSTORE || mem_re) ? addr : '0;
  assign mem_wdata = state == WSTORE ? shreg[DATA_LEN-1:0] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      is_write <= 1'b0;
      addr <= '0;
      burst <= '0;
      cnt <= '0;
      shreg <= '0;
`ifdef SLAVE_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (beat && (write_en ^ read_en)) begin
          is_write <= write_en;
          addr <= {rx_address, addr[ADDR_LEN-1:1]};
          burst <= {rx_burst_number, burst[BURST_LEN-1:1]};
          cnt <= CW'(1);
          state <= HDR;
`ifdef SLAVE_PARITY_EN
          parity_err <= 1'b0;
`endif
        end
        HDR: if (beat) begin
          if (cnt < A_END) addr <= {rx_address, addr[ADDR_LEN-1:1]};
          if (cnt < B_END) burst <= {rx_burst_number, burst[BURST_LEN-1:1]};
          cnt <= cnt == H_LAST ? '0 : cnt + 1'b1;
          if (cnt == H_LAST) state <= is_write ? WDATA : RFETCH;
        end
        WDATA: if (beat) begin
          shreg <= {rx_data, shreg[WORD_LEN-1:1]};
          cnt <= cnt == W_LAST ? '0 : cnt + 1'b1;
          if (cnt == W_LAST) state <= WSTORE;
        end
        WSTORE: begin
          addr <= addr + 1'b1;
          burst <= burst - 1'b1;
          state <= last_word ? DONE : WDATA;
`ifdef SLAVE_PARITY_EN
          parity_err <= parity_err | !word_ok;
`endif
        end
        RFETCH: state <= RWAIT;
        RWAIT: begin
`ifdef SLAVE_PARITY_EN
          shreg <= {^mem_rdata, mem_rdata};
`else
          shreg <= mem_rdata;
`endif
          cnt <= '0;
          state <= RSHIFT;
        end
        RSHIFT: if (master_ready) begin
          shreg <= shreg >> 1;
          cnt <= cnt == W_LAST ? '0 : cnt + 1'b1;
          if (cnt == W_LAST) begin
            addr <= addr + 1'b1;
            burst <= burst - 1'b1;
            state <= last_word ? DONE : RFETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: random serial master driving slave_port against a word-level memory model.
module tb_slave_port;
  localparam int AL = 12, DL = 8, BL = 13, HL = 13;
`ifdef SLAVE_PARITY_EN
  localparam int WL = DL + 1;
`else
  localparam int WL = DL;
`endif
  logic clk = 0, reset = 0, selected = 0, master_valid = 0, master_ready = 0;
  logic write_en = 0, read_en = 0, rx_address = 0, rx_burst_number = 0, rx_data = 0;
  logic slave_ready, slave_valid, tx_data, rx_done, tx_done, mem_we, mem_re;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata, mem_rdata = '0;
`ifdef SLAVE_PARITY_EN
  logic parity_err;
`endif
  int passed = 0, total = 0, cyc = 0;
  int we_cyc = 0, rx_cyc = 0, rx_cnt = 0, tx_cnt = 0, re_cnt = 0;
  logic [DL-1:0] dut_mem [4096] = '{default: '0};
  logic [DL-1:0] ref_mem [4096] = '{default: '0};
  logic [AL+DL-1:0] wr_q [$];
  logic [2:0] beats [$];
  logic bits [$];
  logic [DL-1:0] wdata_q [$];

  slave_port dut (
    .clk(clk), .reset(reset), .selected(selected), .master_valid(master_valid),
    .master_ready(master_ready), .write_en(write_en), .read_en(read_en),
    .rx_address(rx_address), .rx_burst_number(rx_burst_number), .rx_data(rx_data),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
    .rx_done(rx_done), .tx_done(tx_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
`ifdef SLAVE_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= dut_mem[mem_addr];
    if (mem_we) dut_mem[mem_addr] <= mem_wdata;
  end
  always @(negedge clk) begin
    if (mem_we) begin wr_q.push_back({mem_addr, mem_wdata}); we_cyc = cyc; end
    if (rx_done) begin rx_cnt++; rx_cyc = cyc; end
    if (tx_done) tx_cnt++;
    if (mem_re) re_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return 32'({slave_ready, slave_valid, tx_data, rx_done, tx_done, mem_we, mem_re, |mem_addr, |mem_wdata});
  endfunction

  task automatic mk_hdr(input int a, input int b);
    beats.delete();
    for (int k = 0; k < HL; k++)
      beats.push_back({k < AL ? 1'((a >> k) & 1) : 1'b0, k < BL ? 1'((b >> k) & 1) : 1'b0, 1'($urandom)});
  endtask

  task automatic mk_word(input logic [DL-1:0] d);
    for (int k = 0; k < DL; k++) beats.push_back({2'($urandom), d[k]});
`ifdef SLAVE_PARITY_EN
    beats.push_back({2'($urandom), ^d});
`endif
  endtask

  task automatic send(input logic we, input logic re, input bit rnd, input int stop, output int c0);
    int i = 0, budget = 0;
    c0 = -1;
    while (i < stop && budget < 4000) begin
      @(negedge clk);
      master_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      write_en = we;
      read_en = re;
      {rx_address, rx_burst_number, rx_data} = beats[i];
      #1;
      if (master_valid && slave_ready) begin
        if (i == 0) c0 = cyc;
        i++;
      end
      budget++;
    end
    @(posedge clk);
    #1;
    master_valid = 0;
    write_en = 0;
    read_en = 0;
    if (i < stop) chk("send_timeout", i, stop);
  endtask

  task automatic recv(input int nbits, input bit rnd, input int stall_at);
    int k = 0, budget = 0, stall_n = 0;
    bit prev_stall = 0;
    logic prev_bit = 0;
    bits.delete();
    while (k < nbits && budget < 4000) begin
      @(negedge clk);
      master_ready = (k == stall_at && stall_n < 3) ? 1'b0 : (rnd ? $urandom_range(0, 2) != 0 : 1'b1);
      #1;
      if (slave_valid) begin
        if (prev_stall) chk("tx_hold", 32'(tx_data), 32'(prev_bit));
        if (master_ready) begin bits.push_back(tx_data); k++; end
        else if (k == stall_at) stall_n++;
        prev_stall = !master_ready;
        prev_bit = tx_data;
      end else prev_stall = 0;
      budget++;
    end
    @(posedge clk);
    #1;
    master_ready = 0;
    if (k < nbits) chk("recv_timeout", k, nbits);
  endtask

  task automatic do_write(input int a, input int b, input bit rnd, output int c0);
    int n = b == 0 ? 1 : b;
    int rx0 = rx_cnt;
    logic [DL-1:0] d;
    logic [AL+DL-1:0] exp_q [$];
    wr_q.delete();
    mk_hdr(a, b);
    for (int i = 0; i < n; i++) begin
      d = wdata_q.size() != 0 ? wdata_q.pop_front() : DL'($urandom);
      mk_word(d);
      exp_q.push_back({AL'(a + i), d});
      ref_mem[AL'(a + i)] = d;
    end
    send(1'b1, 1'b0, rnd, beats.size(), c0);
    repeat (4) @(negedge clk);
    chk("wr_count", wr_q.size(), n);
    foreach (exp_q[i]) if (i < wr_q.size()) chk("wr_word", 32'(wr_q[i]), 32'(exp_q[i]));
    chk("rx_done", rx_cnt - rx0, 1);
  endtask

  task automatic do_read(input int a, input int b, input bit rnd, input int stall_at);
    int n = b == 0 ? 1 : b;
    int tx0 = tx_cnt, rx0 = rx_cnt, c0;
    logic [DL-1:0] w;
    mk_hdr(a, b);
    send(1'b0, 1'b1, rnd, beats.size(), c0);
    recv(n * WL, rnd, stall_at);
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++)
      if (bits.size() >= (i + 1) * WL) begin
        for (int j = 0; j < DL; j++) w[j] = bits[i * WL + j];
        chk("rd_word", 32'(w), 32'(ref_mem[AL'(a + i)]));
`ifdef SLAVE_PARITY_EN
        chk("rd_parity", 32'(bits[i * WL + DL]), 32'(^w));
`endif
      end
    chk("tx_done", tx_cnt - tx0, 1);
    chk("rd_no_rx_done", rx_cnt - rx0, 0);
  endtask

  initial begin #500000; $display("FAIL watchdog expired"); $fatal(1, "hung"); end

  initial begin
    int c0, rx0, re0, a, b;
    logic [DL-1:0] pd;
    selected = 1;
    #3;
    chk("reset_outs", outs(), 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("idle_ready", 32'(slave_ready), 1);
    // single word, continuous beats: store lands HDR_LEN+WORD_LEN beats after start
    wdata_q = '{8'h3C};
    do_write(12'h0A5, 1, 0, c0);
    chk("wr_latency", we_cyc - c0, HL + WL);
    chk("rx_done_lat", rx_cyc - we_cyc, 1);
    wdata_q = '{8'h11, 8'h22, 8'h33};
    do_write(12'hFFF, 3, 1, c0);
    wdata_q = '{8'hA5, 8'h5A};
    do_write(12'h010, 2, 0, c0);
    do_read(12'h010, 2, 0, 3);
    // illegal opcodes are ignored in IDLE
    wr_q.delete();
    re0 = re_cnt;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      master_valid = 1;
      write_en = k < 3;
      read_en = k < 3;
      {rx_address, rx_burst_number, rx_data} = 3'($urandom);
    end
    @(posedge clk);
    #1;
    master_valid = 0;
    write_en = 0;
    read_en = 0;
    repeat (2) @(negedge clk);
    chk("illegal_we", wr_q.size(), 0);
    chk("illegal_re", re_cnt - re0, 0);
    do_write(12'h0F0, 0, 1, c0);
    do_read(12'h0F0, 0, 1, -1);
    // reset mid-write after 4 data bits of the first word
    wr_q.delete();
    rx0 = rx_cnt;
    mk_hdr(12'h345, 2);
    mk_word(8'hC3);
    mk_word(8'h96);
    send(1'b1, 1'b0, 0, HL + 4, c0);
    #2 reset = 0;
    #1;
    chk("async_reset_outs", outs(), 0);
    repeat (3) @(negedge clk);
    chk("reset_no_we", wr_q.size(), 0);
    chk("reset_no_done", rx_cnt - rx0, 0);
    reset = 1;
    do_write(12'h345, 1, 0, c0);
`ifdef SLAVE_PARITY_EN
    wr_q.delete();
    rx0 = rx_cnt;
    pd = 8'h3C;
    mk_hdr(12'h200, 1);
    for (int k = 0; k < DL; k++) beats.push_back({2'($urandom), pd[k]});
    beats.push_back({2'($urandom), ~^pd});
    send(1'b1, 1'b0, 0, beats.size(), c0);
    repeat (4) @(negedge clk);
    chk("par_no_we", wr_q.size(), 0);
    chk("par_err_set", 32'(parity_err), 1);
    chk("par_rx_done", rx_cnt - rx0, 1);
    do_write(12'h201, 1, 1, c0);
    chk("par_err_clr", 32'(parity_err), 0);
`else
    pd = '0;
`endif
    for (int t = 0; t < 8; t++) begin
      a = $urandom_range(0, 4095);
      b = $urandom_range(1, 4);
      do_write(a, b, 1, c0);
      do_read(a + int'(pd), $urandom_range(0, 4), 1, -1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
